// File: rtl/av2_frame_pkg.sv
// Shared constants, state encodings and lane helper for the reconstruction frame store.
package av2_frame_pkg;
    localparam int MAX_WIDTH_DEF  = 128;
    localparam int MAX_HEIGHT_DEF = 128;
    localparam int MAX_PIXELS     = MAX_WIDTH_DEF * MAX_HEIGHT_DEF;
    localparam int LANE_BITS      = 8;
    localparam int LANES_DEF      = 16;

    localparam logic [1:0] ST_EMPTY   = 2'd0;
    localparam logic [1:0] ST_FILLING = 2'd1;
    localparam logic [1:0] ST_READY   = 2'd2;
    localparam logic [1:0] ST_STREAM  = 2'd3;

    function automatic logic [LANE_BITS-1:0] lane_byte(
        input logic [LANES_DEF*LANE_BITS-1:0] data,
        input int                             lane
    );
        return data[lane*LANE_BITS +: LANE_BITS];
    endfunction
endpackage

// File: rtl/av2_frame_stream_out.sv
// Raster read-out engine: index counter, synchronous-read pipeline and output register with skid.
module av2_frame_stream_out #(
    parameter int PIXEL_WIDTH = 10
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic [15:0]            width,
    input  logic [15:0]            height,
    input  logic [15:0]            stride,
    output logic                   rd_en,
    output logic [31:0]            rd_addr,
    input  logic [PIXEL_WIDTH-1:0] rd_data,
    output logic [PIXEL_WIDTH-1:0] out_pixel,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic                   out_last,
    output logic                   done
);
    logic                   active_reg;
    logic [15:0]            x_reg, y_reg;
    logic [31:0]            row_base_reg;
    logic                   pend_valid_reg, pend_last_reg;
    logic                   out_valid_reg, out_last_reg;
    logic [PIXEL_WIDTH-1:0] out_pixel_reg;
    logic                   skid_valid_reg, skid_last_reg;
    logic [PIXEL_WIDTH-1:0] skid_pixel_reg;

    logic                   out_valid_next, out_last_next;
    logic [PIXEL_WIDTH-1:0] out_pixel_next;
    logic                   skid_valid_next, skid_last_next;
    logic [PIXEL_WIDTH-1:0] skid_pixel_next;

    logic       pop, issue, last_idx, row_end;
    logic [1:0] occ;

    // Reads in flight plus buffered pixels never exceed the two output slots.
    assign pop      = out_valid_reg & out_ready;
    assign occ      = 2'(out_valid_reg) + 2'(skid_valid_reg) + 2'(pend_valid_reg);
    assign issue    = active_reg && ((occ - 2'(pop)) < 2'd2);
    assign row_end  = (x_reg == width - 16'd1);
    assign last_idx = row_end && (y_reg == height - 16'd1);

    assign rd_en     = issue;
    assign rd_addr   = row_base_reg + 32'(x_reg);
    assign out_pixel = out_pixel_reg;
    assign out_valid = out_valid_reg;
    assign out_last  = out_last_reg;
    assign done      = pop & out_last_reg;

    always_comb begin
        out_valid_next  = out_valid_reg;
        out_pixel_next  = out_pixel_reg;
        out_last_next   = out_last_reg;
        skid_valid_next = skid_valid_reg;
        skid_pixel_next = skid_pixel_reg;
        skid_last_next  = skid_last_reg;
        if (!out_valid_reg || pop) begin
            if (skid_valid_reg) begin
                out_valid_next  = 1'b1;
                out_pixel_next  = skid_pixel_reg;
                out_last_next   = skid_last_reg;
                skid_valid_next = pend_valid_reg;
                skid_pixel_next = rd_data;
                skid_last_next  = pend_last_reg;
            end else begin
                out_valid_next  = pend_valid_reg;
                out_pixel_next  = rd_data;
                out_last_next   = pend_last_reg;
                skid_valid_next = 1'b0;
            end
        end else if (!skid_valid_reg) begin
            skid_valid_next = pend_valid_reg;
            skid_pixel_next = rd_data;
            skid_last_next  = pend_last_reg;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active_reg     <= 1'b0;
            x_reg          <= '0;
            y_reg          <= '0;
            row_base_reg   <= '0;
            pend_valid_reg <= 1'b0;
            pend_last_reg  <= 1'b0;
            out_valid_reg  <= 1'b0;
            out_pixel_reg  <= '0;
            out_last_reg   <= 1'b0;
            skid_valid_reg <= 1'b0;
            skid_pixel_reg <= '0;
            skid_last_reg  <= 1'b0;
        end else begin
            out_valid_reg  <= out_valid_next;
            out_pixel_reg  <= out_pixel_next;
            out_last_reg   <= out_last_next;
            skid_valid_reg <= skid_valid_next;
            skid_pixel_reg <= skid_pixel_next;
            skid_last_reg  <= skid_last_next;
            pend_valid_reg <= issue;
            pend_last_reg  <= issue & last_idx;
            if (start) begin
                active_reg   <= 1'b1;
                x_reg        <= '0;
                y_reg        <= '0;
                row_base_reg <= '0;
            end else if (issue) begin
                if (last_idx) begin
                    active_reg <= 1'b0;
                end
                if (row_end) begin
                    x_reg        <= '0;
                    y_reg        <= y_reg + 16'd1;
                    row_base_reg <= row_base_reg + 32'(stride);
                end else begin
                    x_reg <= x_reg + 16'd1;
                end
            end
        end
    end
endmodule

// File: rtl/av2_recon_frame_store.sv
// Frame buffer behind the tile decoder: 16-lane writes, reference reads, raster read-out.
module av2_recon_frame_store
    import av2_frame_pkg::*;
#(
    parameter int MAX_WIDTH   = 128,
    parameter int MAX_HEIGHT  = 128,
    parameter int PIXEL_WIDTH = 10,
    parameter int LANES       = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [15:0]                frame_width,
    input  logic [15:0]                frame_height,
    input  logic [LANES*LANE_BITS-1:0] recon_data,
    input  logic [31:0]                recon_addr,
    input  logic                       recon_wr_en,
    input  logic                       tile_done,
    input  logic [31:0]                ref_read_addr,
    input  logic                       ref_read_en,
    output logic [PIXEL_WIDTH-1:0]     ref_pixel_data,
    input  logic                       out_start,
    output logic [PIXEL_WIDTH-1:0]     out_pixel,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic                       out_last,
    output logic                       frame_ready,
    output logic                       busy,
    output logic                       addr_err,
    output logic                       overrun,
    input  logic                       clear_err,
    output logic [15:0]                beat_count
);
    localparam int          DEPTH    = MAX_WIDTH * MAX_HEIGHT;
    localparam int          ADDR_W   = $clog2(DEPTH);
    localparam logic [32:0] DEPTH_33 = 33'(DEPTH);
    localparam logic [31:0] DEPTH_32 = 32'(DEPTH);
    localparam logic [15:0] MAX_W16  = 16'(MAX_WIDTH);
    localparam logic [15:0] MAX_H16  = 16'(MAX_HEIGHT);

    logic [PIXEL_WIDTH-1:0] mem [DEPTH];

    logic [1:0]             state_reg, state_next;
    logic [15:0]            beat_count_reg, beat_count_next;
    logic                   addr_err_reg, overrun_reg;
    logic [15:0]            w_lat_reg, h_lat_reg, stride_reg;
    logic [PIXEL_WIDTH-1:0] ref_data_reg, srd_data_reg;

    logic [LANES-1:0]       lane_ok;
    logic [ADDR_W-1:0]      lane_addr [LANES];
    logic [PIXEL_WIDTH-1:0] lane_pix  [LANES];
    logic                   ref_ok, srd_ok, srd_en;
    logic [31:0]            srd_addr;
    logic [15:0]            w_clamp, h_clamp;
    logic                   honour_start, stream_done;
    logic                   wr_err, rd_err, overrun_set;

    // Lane addresses are formed 33 bits wide so a beat near 2^32 cannot wrap into range.
    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
        logic [32:0] full_addr;
        assign full_addr     = {1'b0, recon_addr} + 33'(gi);
        assign lane_ok[gi]   = full_addr < DEPTH_33;
        assign lane_addr[gi] = full_addr[ADDR_W-1:0];
        assign lane_pix[gi]  = PIXEL_WIDTH'(lane_byte(recon_data, gi));
    end

    always_ff @(posedge clk) begin
        if (recon_wr_en) begin
            for (int k = 0; k < LANES; k++) begin
                if (lane_ok[k]) begin
                    mem[lane_addr[k]] <= lane_pix[k];
                end
            end
        end
    end

    assign ref_ok = ref_read_addr < DEPTH_32;
    assign srd_ok = srd_addr < DEPTH_32;

    // Both read ports see pre-write contents when a write lands on the same address.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ref_data_reg <= '0;
            srd_data_reg <= '0;
        end else begin
            if (ref_read_en) begin
                ref_data_reg <= ref_ok ? mem[ref_read_addr[ADDR_W-1:0]] : '0;
            end
            if (srd_en) begin
                srd_data_reg <= srd_ok ? mem[srd_addr[ADDR_W-1:0]] : '0;
            end
        end
    end

    assign w_clamp      = (frame_width  > MAX_W16) ? MAX_W16 : frame_width;
    assign h_clamp      = (frame_height > MAX_H16) ? MAX_H16 : frame_height;
    assign honour_start = (state_reg == ST_READY) && out_start &&
                          (w_clamp != 16'd0) && (h_clamp != 16'd0);

    assign wr_err      = recon_wr_en && !(&lane_ok);
    assign rd_err      = ref_read_en && !ref_ok;
    assign overrun_set = recon_wr_en && ((state_reg == ST_STREAM) || honour_start);

    always_comb begin
        state_next      = state_reg;
        beat_count_next = beat_count_reg;
        if (recon_wr_en && beat_count_reg != 16'hFFFF) begin
            beat_count_next = beat_count_reg + 16'd1;
        end
        case (state_reg)
            ST_EMPTY: begin
                if (recon_wr_en) begin
                    state_next      = ST_FILLING;
                    beat_count_next = 16'd1;
                end
            end
            ST_FILLING: begin
                if (tile_done) begin
                    state_next = ST_READY;
                end
            end
            ST_READY: begin
                if (honour_start) begin
                    state_next = ST_STREAM;
                end else if (recon_wr_en) begin
                    state_next      = ST_FILLING;
                    beat_count_next = 16'd1;
                end
            end
            default: begin
                if (stream_done) begin
                    state_next = ST_READY;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= ST_EMPTY;
            beat_count_reg <= '0;
            addr_err_reg   <= 1'b0;
            overrun_reg    <= 1'b0;
            w_lat_reg      <= '0;
            h_lat_reg      <= '0;
            stride_reg     <= '0;
        end else begin
            state_reg      <= state_next;
            beat_count_reg <= beat_count_next;
            addr_err_reg   <= (addr_err_reg & ~clear_err) | wr_err | rd_err;
            overrun_reg    <= (overrun_reg & ~clear_err) | overrun_set;
            if (honour_start) begin
                w_lat_reg  <= w_clamp;
                h_lat_reg  <= h_clamp;
                stride_reg <= frame_width;
            end
        end
    end

    av2_frame_stream_out #(
        .PIXEL_WIDTH(PIXEL_WIDTH)
    ) u_stream_out (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (honour_start),
        .width    (w_lat_reg),
        .height   (h_lat_reg),
        .stride   (stride_reg),
        .rd_en    (srd_en),
        .rd_addr  (srd_addr),
        .rd_data  (srd_data_reg),
        .out_pixel(out_pixel),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_last (out_last),
        .done     (stream_done)
    );

    assign ref_pixel_data = ref_data_reg;
    assign frame_ready    = (state_reg == ST_READY);
    assign busy           = (state_reg == ST_STREAM);
    assign addr_err       = addr_err_reg;
    assign overrun        = overrun_reg;
    assign beat_count     = beat_count_reg;
endmodule

// File: tb/tb_av2_recon_frame_store.sv
// Directed bench for av2_recon_frame_store: writes, reference reads, raster streaming, error flags.
module tb_av2_recon_frame_store;
    logic         clk = 1'b0;
    logic         rst_n;
    logic [15:0]  frame_width, frame_height;
    logic [127:0] recon_data;
    logic [31:0]  recon_addr;
    logic         recon_wr_en, tile_done;
    logic [31:0]  ref_read_addr;
    logic         ref_read_en;
    logic [9:0]   ref_pixel_data;
    logic         out_start;
    logic [9:0]   out_pixel;
    logic         out_valid, out_ready, out_last;
    logic         frame_ready, busy, addr_err, overrun, clear_err;
    logic [15:0]  beat_count;

    int tests_run    = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    av2_recon_frame_store dut (
        .clk(clk), .rst_n(rst_n), .frame_width(frame_width), .frame_height(frame_height),
        .recon_data(recon_data), .recon_addr(recon_addr), .recon_wr_en(recon_wr_en),
        .tile_done(tile_done), .ref_read_addr(ref_read_addr), .ref_read_en(ref_read_en),
        .ref_pixel_data(ref_pixel_data), .out_start(out_start), .out_pixel(out_pixel),
        .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last),
        .frame_ready(frame_ready), .busy(busy), .addr_err(addr_err), .overrun(overrun),
        .clear_err(clear_err), .beat_count(beat_count)
    );

    // Stimulus helpers: all are entered and left on a falling edge.
    task automatic load_beat(input logic [31:0] addr, input logic [7:0] base);
        for (int k = 0; k < 16; k++) recon_data[8*k +: 8] = base + 8'(k);
        recon_addr  = addr;
        recon_wr_en = 1'b1;
    endtask

    task automatic drive_beat(input logic [31:0] addr, input logic [7:0] base);
        load_beat(addr, base);
        @(negedge clk);
        recon_wr_en = 1'b0;
    endtask

    task automatic ref_read(input logic [31:0] addr);
        ref_read_addr = addr;
        ref_read_en   = 1'b1;
        @(negedge clk);
        ref_read_en   = 1'b0;
    endtask

    task automatic pulse_tile_done();
        tile_done = 1'b1;
        @(negedge clk);
        tile_done = 1'b0;
    endtask

    task automatic pulse_clear();
        clear_err = 1'b1;
        @(negedge clk);
        clear_err = 1'b0;
    endtask

    // Collects a stream whose pixel n is expected to equal n; returns error tallies.
    task automatic collect_stream(input bit toggle, input int npix, output int got,
                                  output int data_err, output int last_err,
                                  output int stable_err, output int span);
        logic       stalled;
        logic [9:0] hold_pix;
        logic       hold_last;
        int         cyc, first;
        got = 0; data_err = 0; last_err = 0; stable_err = 0; span = 0;
        stalled = 1'b0; hold_pix = '0; hold_last = 1'b0; cyc = 0; first = -1;
        while (got < npix && cyc < 4*npix + 50) begin
            if (stalled && (out_valid !== 1'b1 || out_pixel !== hold_pix || out_last !== hold_last))
                stable_err++;
            out_ready = toggle ? (cyc % 2 == 0) : 1'b1;
            stalled   = 1'b0;
            if (out_valid === 1'b1) begin
                if (first < 0) first = cyc;
                if (out_ready) begin
                    if (out_pixel !== 10'(got)) data_err++;
                    if (out_last !== (got == npix - 1)) last_err++;
                    got++;
                    if (got == npix) span = cyc - first + 1;
                end else begin
                    stalled   = 1'b1;
                    hold_pix  = out_pixel;
                    hold_last = out_last;
                end
            end
            @(negedge clk);
            cyc++;
        end
        out_ready = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        frame_width = 16'd16; frame_height = 16'd16;
        recon_data = '0; recon_addr = '0; recon_wr_en = 0; tile_done = 0;
        ref_read_addr = '0; ref_read_en = 0; out_start = 0; out_ready = 1; clear_err = 0;
        repeat (3) @(negedge clk);
        tests_run++;
        if ({ref_pixel_data, out_pixel, out_valid, out_last, frame_ready, busy, addr_err, overrun, beat_count} !== '0) begin
            tests_failed++;
            $display("FAIL reset_outputs: got ref=%h pix=%h v=%b l=%b fr=%b busy=%b ae=%b ov=%b bc=%h required all zero",
                     ref_pixel_data, out_pixel, out_valid, out_last, frame_ready, busy, addr_err, overrun, beat_count);
        end
        rst_n = 1'b1;
        @(negedge clk);
        $display("[TB] test_reset done");
    endtask

    task automatic test_write_ref();
        drive_beat(32'd0, 8'h00);
        ref_read(32'd5);
        tests_run++;
        if (ref_pixel_data !== 10'h005) begin
            tests_failed++;
            $display("FAIL ref_read_5: got %h required %h", ref_pixel_data, 10'h005);
        end
        tests_run++;
        if (beat_count !== 16'd1 || frame_ready !== 1'b0 || busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL first_beat_state: got bc=%0d fr=%b busy=%b required bc=1 fr=0 busy=0", beat_count, frame_ready, busy);
        end
        ref_read_addr = 32'd7;
        repeat (2) @(negedge clk);
        tests_run++;
        if (ref_pixel_data !== 10'h005) begin
            tests_failed++;
            $display("FAIL ref_hold: got %h required %h", ref_pixel_data, 10'h005);
        end
        $display("[TB] test_write_ref done");
    endtask

    task automatic test_stream_full();
        int got, derr, lerr, serr, span;
        for (int r = 0; r < 16; r++) drive_beat(32'(16*r), 8'(16*r));
        tests_run++;
        if (beat_count !== 16'd17) begin
            tests_failed++;
            $display("FAIL fill_beat_count: got %0d required 17", beat_count);
        end
        pulse_tile_done();
        tests_run++;
        if (frame_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL tile_done_ready: got %b required 1", frame_ready);
        end
        out_ready = 1'b1;
        out_start = 1'b1;
        @(negedge clk);
        out_start = 1'b0;
        tests_run++;
        if (out_valid !== 1'b0 || busy !== 1'b1) begin
            tests_failed++;
            $display("FAIL start_cycle0: got v=%b busy=%b required v=0 busy=1", out_valid, busy);
        end
        @(negedge clk);
        tests_run++;
        if (out_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL start_cycle1: got v=%b required 0", out_valid);
        end
        @(negedge clk);
        tests_run++;
        if (out_valid !== 1'b1) begin
            tests_failed++;
            $display("FAIL start_cycle2: got v=%b required 1", out_valid);
        end
        collect_stream(1'b0, 256, got, derr, lerr, serr, span);
        tests_run++;
        if (got !== 256 || derr !== 0 || lerr !== 0) begin
            tests_failed++;
            $display("FAIL stream_full: got n=%0d data_err=%0d last_err=%0d required n=256 errs=0", got, derr, lerr);
        end
        tests_run++;
        if (span !== 256) begin
            tests_failed++;
            $display("FAIL stream_rate: got %0d cycles required 256", span);
        end
        tests_run++;
        if (out_valid !== 1'b0 || frame_ready !== 1'b1 || busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL stream_end: got v=%b fr=%b busy=%b required v=0 fr=1 busy=0", out_valid, frame_ready, busy);
        end
        $display("[TB] test_stream_full done");
    endtask

    task automatic test_stream_stall();
        int got, derr, lerr, serr, span;
        out_start = 1'b1;
        @(negedge clk);
        out_start = 1'b0;
        collect_stream(1'b1, 256, got, derr, lerr, serr, span);
        tests_run++;
        if (got !== 256 || derr !== 0 || lerr !== 0) begin
            tests_failed++;
            $display("FAIL stall_stream: got n=%0d data_err=%0d last_err=%0d required n=256 errs=0", got, derr, lerr);
        end
        tests_run++;
        if (serr !== 0) begin
            tests_failed++;
            $display("FAIL stall_stable: got %0d unstable cycles required 0", serr);
        end
        tests_run++;
        if (out_valid !== 1'b0 || frame_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL stall_end: got v=%b fr=%b required v=0 fr=1", out_valid, frame_ready);
        end
        $display("[TB] test_stream_stall done");
    endtask

    task automatic test_addr_err();
        drive_beat(32'd16376, 8'hA0);
        tests_run++;
        if (addr_err !== 1'b1 || beat_count !== 16'd1) begin
            tests_failed++;
            $display("FAIL edge_write_err: got ae=%b bc=%0d required ae=1 bc=1", addr_err, beat_count);
        end
        ref_read(32'd0);
        tests_run++;
        if (ref_pixel_data !== 10'h000) begin
            tests_failed++;
            $display("FAIL dropped_lane_nowrap: got %h required %h", ref_pixel_data, 10'h000);
        end
        ref_read(32'd16383);
        tests_run++;
        if (ref_pixel_data !== 10'h0A7) begin
            tests_failed++;
            $display("FAIL last_lane_stored: got %h required %h", ref_pixel_data, 10'h0A7);
        end
        pulse_clear();
        tests_run++;
        if (addr_err !== 1'b0) begin
            tests_failed++;
            $display("FAIL clear_err: got %b required 0", addr_err);
        end
        clear_err = 1'b1;
        ref_read(32'd16384);
        clear_err = 1'b0;
        tests_run++;
        if (ref_pixel_data !== 10'h000 || addr_err !== 1'b1) begin
            tests_failed++;
            $display("FAIL oob_read_set_wins: got data=%h ae=%b required data=000 ae=1", ref_pixel_data, addr_err);
        end
        pulse_clear();
        $display("[TB] test_addr_err done");
    endtask

    task automatic test_overrun();
        int got, derr, lerr, serr, span;
        pulse_tile_done();
        load_beat(32'd4096, 8'h30);
        out_start = 1'b1;
        @(negedge clk);
        out_start = 1'b0; recon_wr_en = 1'b0;
        tests_run++;
        if (busy !== 1'b1 || overrun !== 1'b1) begin
            tests_failed++;
            $display("FAIL start_beats_write: got busy=%b ov=%b required busy=1 ov=1", busy, overrun);
        end
        drive_beat(32'd4112, 8'h40);
        collect_stream(1'b0, 256, got, derr, lerr, serr, span);
        tests_run++;
        if (got !== 256 || derr !== 0 || lerr !== 0) begin
            tests_failed++;
            $display("FAIL overrun_stream: got n=%0d data_err=%0d last_err=%0d required n=256 errs=0", got, derr, lerr);
        end
        tests_run++;
        if (overrun !== 1'b1 || frame_ready !== 1'b1 || beat_count !== 16'd3) begin
            tests_failed++;
            $display("FAIL overrun_flags: got ov=%b fr=%b bc=%0d required ov=1 fr=1 bc=3", overrun, frame_ready, beat_count);
        end
        ref_read(32'd4096);
        tests_run++;
        if (ref_pixel_data !== 10'h030) begin
            tests_failed++;
            $display("FAIL start_write_stored: got %h required %h", ref_pixel_data, 10'h030);
        end
        ref_read(32'd4127);
        tests_run++;
        if (ref_pixel_data !== 10'h04F) begin
            tests_failed++;
            $display("FAIL stream_write_stored: got %h required %h", ref_pixel_data, 10'h04F);
        end
        $display("[TB] test_overrun done");
    endtask

    task automatic test_read_first();
        load_beat(32'd0, 8'h50);
        ref_read(32'd3);
        recon_wr_en = 1'b0;
        tests_run++;
        if (ref_pixel_data !== 10'h003 || beat_count !== 16'd1 || frame_ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL read_first: got data=%h bc=%0d fr=%b required data=003 bc=1 fr=0", ref_pixel_data, beat_count, frame_ready);
        end
        ref_read(32'd3);
        tests_run++;
        if (ref_pixel_data !== 10'h053) begin
            tests_failed++;
            $display("FAIL read_after_write: got %h required %h", ref_pixel_data, 10'h053);
        end
        pulse_clear();
        tests_run++;
        if (overrun !== 1'b0) begin
            tests_failed++;
            $display("FAIL clear_overrun: got %b required 0", overrun);
        end
        $display("[TB] test_read_first done");
    endtask

    task automatic test_zero_width();
        int seen;
        pulse_tile_done();
        frame_width = 16'd0;
        out_start = 1'b1;
        @(negedge clk);
        out_start = 1'b0;
        seen = 0;
        for (int i = 0; i < 5; i++) begin
            if (out_valid !== 1'b0) seen++;
            @(negedge clk);
        end
        tests_run++;
        if (seen !== 0 || frame_ready !== 1'b1 || busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL zero_width: got valid_cycles=%0d fr=%b busy=%b required 0/1/0", seen, frame_ready, busy);
        end
        frame_width = 16'd16;
        $display("[TB] test_zero_width done");
    endtask

    task automatic test_reset_mid_stream();
        out_start = 1'b1;
        @(negedge clk);
        out_start = 1'b0;
        out_ready = 1'b0;
        repeat (4) @(negedge clk);
        tests_run++;
        if (out_valid !== 1'b1 || busy !== 1'b1) begin
            tests_failed++;
            $display("FAIL pre_reset_stream: got v=%b busy=%b required 1/1", out_valid, busy);
        end
        rst_n = 1'b0;
        #1;
        tests_run++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || frame_ready !== 1'b0 || beat_count !== 16'd0) begin
            tests_failed++;
            $display("FAIL mid_reset: got v=%b busy=%b fr=%b bc=%0d required all 0", out_valid, busy, frame_ready, beat_count);
        end
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        drive_beat(32'd64, 8'h11);
        pulse_tile_done();
        tests_run++;
        if (beat_count !== 16'd1 || frame_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL post_reset_empty: got bc=%0d fr=%b required bc=1 fr=1", beat_count, frame_ready);
        end
        $display("[TB] test_reset_mid_stream done");
    endtask

    initial begin
        test_reset();
        test_write_ref();
        test_stream_full();
        test_stream_stall();
        test_addr_err();
        test_overrun();
        test_read_first();
        test_zero_width();
        test_reset_mid_stream();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end
endmodule
